// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO controller slice.
//   DW    - default data width in bits
//   AW    - default address width (DEPTH = 2**AW entries)
//   ptr_t - read/write pointer type (AW bits, wraps naturally)
//   cnt_t - occupancy type (AW+1 bits, holds 0..DEPTH)
package fifo_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/fifo_store.sv
// fifo_store: DEPTH x DW distributed-RAM-style storage.
// Combinational read on ra, synchronous write on wa. Separate read and
// write addresses let the controller dequeue and enqueue in the same cycle.
//   clk - write clock
//   we  - write enable
//   wa  - write address
//   d   - write data
//   ra  - read address
//   spo - combinational read data at ra
// Contents are deliberately not reset.
module fifo_store #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] spo
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= d;
    end

    // A same-cycle write to ra lands after the edge, so a read here sees
    // the old word (needed when full and both ops fire with wp == rp).
    assign spo = mem[ra];

endmodule

// File: rtl/fifo_queue_ctrl.sv
// fifo_queue_ctrl: synchronous FIFO controller in front of fifo_store.
// Turns enqueue/dequeue requests into store traffic and registers the
// dequeued word.
//   clk       - system clock, all state on rising edge
//   rst       - synchronous active-high reset
//   enq       - enqueue request (edge- or level-qualified, see EDGE_DETECT)
//   in        - data to enqueue, sampled on the accepting edge
//   deq       - dequeue request
//   out       - last dequeued word, registered
//   out_valid - one-cycle pulse: out updated on the preceding edge
//   full      - count == 2**AW
//   empty     - count == 0
//   count     - current occupancy 0..2**AW
module fifo_queue_ctrl #(
    parameter int DW          = fifo_pkg::DW,
    parameter int AW          = fifo_pkg::AW,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  logic [DW-1:0] in,
    input  logic          deq,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    import fifo_pkg::*;

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          enq_q, enq_d, deq_q, deq_d;

    logic          enq_r, deq_r, do_enq, do_deq;
    logic [DW-1:0] rd_data;

    fifo_store #(
        .DW (DW),
        .AW (AW)
    ) u_store (
        .clk (clk),
        .we  (do_enq),
        .wa  (wp_q),
        .d   (in),
        .ra  (rp_q),
        .spo (rd_data)
    );

    always_comb begin
        enq_d = enq;
        deq_d = deq;

        // History flops reset to 0, so a request held through reset
        // release still counts as a rising edge.
        enq_r = EDGE_DETECT ? (enq & ~enq_q) : enq;
        deq_r = EDGE_DETECT ? (deq & ~deq_q) : deq;

        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);

        do_deq = deq_r & ~empty;
        // A full queue still accepts a write when a read frees a slot
        // in the same cycle.
        do_enq = enq_r & (~full | do_deq);

        rp_d        = rp_q;
        wp_d        = wp_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        count_d     = count_q;

        if (do_enq) wp_d = wp_q + 1'b1;

        if (do_deq) begin
            out_d       = rd_data;
            out_valid_d = 1'b1;
            rp_d        = rp_q + 1'b1;
        end

        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q        <= '0;
            wp_q        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
        end else begin
            rp_q        <= rp_d;
            wp_q        <= wp_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            enq_q       <= enq_d;
            deq_q       <= deq_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_fifo_queue_ctrl.sv
// Directed bench for fifo_queue_ctrl. Instance dut uses edge-qualified
// requests; instance dut_lvl uses level requests for the hold-high case.
module tb_fifo_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq, deq;
    logic [7:0] din;
    logic [7:0] out;
    logic       out_valid, full, empty;
    logic [4:0] count;

    logic       enq2, deq2;
    logic [7:0] din2;
    logic [7:0] out2;
    logic       out_valid2, full2, empty2;
    logic [4:0] count2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_queue_ctrl #(.DW(8), .AW(4), .EDGE_DETECT(1'b1)) dut (
        .clk(clk), .rst(rst), .enq(enq), .in(din), .deq(deq),
        .out(out), .out_valid(out_valid), .full(full), .empty(empty),
        .count(count)
    );

    fifo_queue_ctrl #(.DW(8), .AW(4), .EDGE_DETECT(1'b0)) dut_lvl (
        .clk(clk), .rst(rst), .enq(enq2), .in(din2), .deq(deq2),
        .out(out2), .out_valid(out_valid2), .full(full2), .empty(empty2),
        .count(count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single-cycle enqueue pulse followed by a low cycle to re-arm the edge.
    task automatic enq_pulse(input logic [7:0] v);
        enq = 1'b1; din = v;
        step();
        enq = 1'b0;
        step();
    endtask

    // Dequeue pulse; checks the registered word and pulse right after the edge.
    task automatic deq_pulse(input string tag, input logic [7:0] exp);
        deq = 1'b1;
        step();
        chk({tag, "_out"}, 32'(out), 32'(exp));
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        deq = 1'b0;
        step();
        chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enq = 1'b0; deq = 1'b0; din = '0;
        enq2 = 1'b0; deq2 = 1'b0; din2 = '0;

        // Reset
        step(); step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_out",   32'(out),   32'd0);
        chk("rst_ov",    32'(out_valid), 32'd0);
        rst = 1'b0;
        step();

        // Fill
        for (int i = 0; i < 16; i++) enq_pulse(8'(8'h10 + i));
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Ignored enq when full
        enq_pulse(8'hAA);
        chk("ovf_count", 32'(count), 32'd16);

        // Drain order (0xAA must not appear, proving wp was untouched)
        for (int i = 0; i < 16; i++) deq_pulse("drain", 8'(8'h10 + i));
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Deq when empty
        deq = 1'b1; step();
        chk("udf_out", 32'(out), 32'h1F);
        chk("udf_ov",  32'(out_valid), 32'd0);
        deq = 1'b0; step();

        // Wrap-around
        for (int i = 0; i < 10; i++) enq_pulse(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) deq_pulse("wrap_a", 8'(8'h20 + i));
        for (int i = 0; i < 12; i++) enq_pulse(8'(8'h40 + i));
        chk("wrap_count", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) deq_pulse("wrap_b", 8'(8'h40 + i));
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous while full
        for (int i = 0; i < 16; i++) enq_pulse(8'(8'h60 + i));
        enq = 1'b1; deq = 1'b1; din = 8'h77;
        step();
        chk("sim_full_out",   32'(out),   32'h60);
        chk("sim_full_ov",    32'(out_valid), 32'd1);
        chk("sim_full_count", 32'(count), 32'd16);
        enq = 1'b0; deq = 1'b0;
        step();
        for (int i = 1; i < 16; i++) deq_pulse("sim_drain", 8'(8'h60 + i));
        deq_pulse("sim_last", 8'h77);
        chk("sim_drain_count", 32'(count), 32'd0);

        // Simultaneous while empty
        enq = 1'b1; deq = 1'b1; din = 8'h88;
        step();
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_ov",    32'(out_valid), 32'd0);
        chk("sim_empty_out",   32'(out), 32'h77);
        enq = 1'b0; deq = 1'b0;
        step();
        deq_pulse("sim_empty_rd", 8'h88);

        // Held request: edge mode takes one, level mode takes eight
        enq = 1'b1; din = 8'h33; enq2 = 1'b1; din2 = 8'h33;
        for (int i = 0; i < 8; i++) step();
        enq = 1'b0; enq2 = 1'b0;
        step();
        chk("edge_count",  32'(count),  32'd1);
        chk("level_count", 32'(count2), 32'd8);
        deq_pulse("edge_rd", 8'h33);

        // Reset mid-operation with a concurrent enq
        for (int i = 0; i < 5; i++) enq_pulse(8'(8'hC0 + i));
        chk("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1; enq = 1'b1; din = 8'hEE;
        step();
        rst = 1'b0; enq = 1'b0;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_out",   32'(out),   32'd0);
        chk("mrst_ov",    32'(out_valid), 32'd0);
        chk("mrst_lvl",   32'(count2), 32'd0);
        step();
        enq_pulse(8'h5A);
        deq_pulse("post_rst", 8'h5A);
        chk("post_rst_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fifo_queue_ctrl.md
Name: fifo_queue_ctrl

Overview:
- Synchronous FIFO controller built around a 16x8 distributed-RAM-style store: combinational read, write on clock edge.
- Sits directly upstream of the storage array. Turns enqueue/dequeue requests into address, write-data and write-enable traffic.
- Registers the dequeued word for downstream display or compute logic.
- Requests may come from debounced buttons, so optional rising-edge detection is built in.

Parameters:
- DW, 8, data width in bits.
- AW, 4, address width; depth = 2**AW = 16 entries.
- EDGE_DETECT, 1, 1 = a request is acted on only at its 0->1 transition; 0 = level, one operation per cycle while high.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- enq  in  1  enqueue request.
- in  in  DW  data to enqueue, sampled on the accepting edge.
- deq  in  1  dequeue request.
- out  out  DW  last dequeued word, registered.
- out_valid  out  1  one-cycle pulse: out updated on the preceding edge.
- full  out  1  count == 2**AW.
- empty  out  1  count == 0.
- count  out  AW+1  current occupancy, 0..16.

Behaviour:
- Reset (rst high at an edge):
  - rp = 0, wp = 0, count = 0, out = 0, out_valid = 0, full = 0, empty = 1.
  - Edge-detect history registers cleared to 0, so a request already held high when rst falls counts as a rising edge on the first cycle.
  - Storage contents not cleared.
  - rst overrides any simultaneous request; a mid-operation reset discards all queued data.
- Request qualification:
  - EDGE_DETECT=1: enq_r = enq & ~enq_q; deq_r likewise, using a 1-cycle history flop.
  - EDGE_DETECT=0: enq_r = enq; deq_r = deq.
- Acceptance, decided combinationally from current state:
  - do_deq = deq_r & ~empty.
  - do_enq = enq_r & (~full | do_deq).
- Enqueue (do_enq):
  - Storage write at wp with data in, via we = do_enq.
  - wp <= wp + 1, wrapping modulo 16 by natural AW-bit overflow.
- Dequeue (do_deq):
  - out <= mem[rp], using the combinational read of the current rp.
  - rp <= rp + 1 with wrap; out_valid <= 1.
  - On all other cycles out_valid <= 0 and out holds.
- Count update:
  - +1 on enq only, -1 on deq only, unchanged on both or neither.
  - full and empty are registered from the next count value, or derived combinationally from count; either way they must be exact in the same cycle count changes.
- Simultaneous enq and deq:
  - Non-empty and not full: both act, count unchanged.
  - Full: both act. Read returns the old word at rp before the write lands; wp == rp is legal here. Count stays 16.
  - Empty: deq ignored, enq acts, count becomes 1. No same-cycle bypass; out and out_valid unchanged.
- Ignored requests:
  - Enq when full without a deq: no write, no pointer change.
  - Deq when empty: out holds, out_valid stays 0.
- Latency:
  - Request accepted at edge N: out/out_valid visible after edge N.
  - An enqueued word is readable by a deq accepted at edge N+1 or later.
- No X propagation: out only ever loads from written locations.

Decomposition:
- Shared package fifo_pkg: DW, AW and DEPTH constants, plus ptr_t (AW bits) and cnt_t (AW+1 bits) typedefs.
- One sub-module, fifo_store:
  - Ports a, d, clk, we, spo: AW-bit address, DW-bit write data, write enable, combinational read data.
  - The controller muxes a = do_enq ? wp : rp. Simultaneous operation requires separate read and write addresses, so fifo_store provides a dual-port variant: write address wa, read address ra, read data spo.
  - fifo_store is the only storage instance; the controller holds pointers, count, output register and edge logic.

Test Plan:
- Reset then fill: rst 2 cycles; enq 16 single-cycle pulses with in = 0x10..0x1F.
  - -> count 16, full=1, empty=0.
  - A 17th enq with in = 0xAA leaves count 16 and wp unchanged.
- Drain order: 16 deq pulses after the fill.
  - -> out sequence 0x10..0x1F, each with a 1-cycle out_valid.
  - Final count 0, empty=1; an extra deq leaves out = 0x1F and out_valid = 0.
- Wrap-around: enq 10, deq 10, enq 12 (0x40..0x4B), deq 12.
  - -> out 0x40..0x4B in order; pointers wrapped past 15 without data loss.
- Simultaneous:
  - While full, pulse enq (in = 0x77) and deq together -> out = oldest word, count stays 16, and 0x77 emerges last on drain.
  - While empty, both together -> count 1, out_valid = 0.
- Edge detect (EDGE_DETECT=1): hold enq high for 8 cycles with in = 0x33 -> exactly one entry, count 1. Same test with EDGE_DETECT=0 -> count 8.
- Reset mid-operation: after 5 enq, assert rst for 1 cycle concurrently with enq.
  - -> count 0, empty=1, out = 0, out_valid = 0.
  - The next enq of 0x5A followed by a deq yields out = 0x5A.
